// File: rtl/sdf_output_reorder_pkg.sv
// Shared types and sizing helpers for the SDF output reorder buffer.
package sdf_output_reorder_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 4;

    typedef logic                  bank_sel_t;
    typedef logic [DATA_WIDTH-1:0] coef_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    function automatic bank_sel_t flip_bank(input bank_sel_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/sdf_reorder_bank.sv
// One ping-pong bank: single write port, registered read port, depth 2**address_width.
module sdf_reorder_bank
    import sdf_output_reorder_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH,
    parameter int unsigned address_width = ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [address_width-1:0] waddr,
    input  logic [data_width-1:0]    wdata,
    input  logic                     re,
    input  logic [address_width-1:0] raddr,
    output logic [data_width-1:0]    rdata
);

    localparam int unsigned DEPTH = depth_of(address_width);

    logic [data_width-1:0] mem_q [DEPTH];
    logic [data_width-1:0] rdata_q;

    // Storage is intentionally not reset; validity is tracked by the control logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdf_output_reorder.sv
// Ping-pong reorder buffer: captures scrambled SDF output by address and streams
// each completed polynomial out in natural order over valid/ready.
module sdf_output_reorder
    import sdf_output_reorder_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH,
    parameter int unsigned address_width = ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [data_width-1:0]    sdf_out,
    input  logic [address_width-1:0] out_address,
    input  logic                     data_valid,
    output logic [data_width-1:0]    dout,
    output logic [address_width-1:0] dout_index,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     frame_done,
    output logic                     overflow
);

    localparam logic [address_width-1:0] LAST_IDX = {address_width{1'b1}};

    bank_sel_t                  wbank_q, wbank_d;
    logic [address_width-1:0]   wcount_q, wcount_d;
    logic [1:0]                 full_q, full_d;
    logic                       overflow_q, overflow_d;
    bank_sel_t                  ibank_q, ibank_d;
    logic [address_width-1:0]   raddr_q, raddr_d;
    bank_sel_t                  rbank_q, rbank_d;
    logic                       s1_valid_q, s1_valid_d;
    logic [address_width-1:0]   s1_index_q, s1_index_d;
    bank_sel_t                  s1_bank_q, s1_bank_d;
    logic [data_width-1:0]      dout_q, dout_d;
    logic [address_width-1:0]   dout_index_q, dout_index_d;
    logic                       dout_valid_q, dout_valid_d;

    logic                       we0, we1, re0, re1;
    logic [data_width-1:0]      rdata0, rdata1;
    logic                       wr_ok, out_fire, load_out, issue;

    sdf_reorder_bank #(.data_width(data_width), .address_width(address_width)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (out_address),
        .wdata (sdf_out),
        .re    (re0),
        .raddr (raddr_q),
        .rdata (rdata0)
    );

    sdf_reorder_bank #(.data_width(data_width), .address_width(address_width)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (out_address),
        .wdata (sdf_out),
        .re    (re1),
        .raddr (raddr_q),
        .rdata (rdata1)
    );

    // Issue pointer (ibank) runs ahead of the release pointer (rbank) so the
    // next full bank starts reading while the previous one's tail still drains.
    always_comb begin
        wbank_d      = wbank_q;
        wcount_d     = wcount_q;
        full_d       = full_q;
        overflow_d   = overflow_q;
        ibank_d      = ibank_q;
        raddr_d      = raddr_q;
        rbank_d      = rbank_q;
        s1_valid_d   = s1_valid_q;
        s1_index_d   = s1_index_q;
        s1_bank_d    = s1_bank_q;
        dout_d       = dout_q;
        dout_index_d = dout_index_q;
        dout_valid_d = dout_valid_q;

        wr_ok    = data_valid & ~full_q[wbank_q];
        we0      = wr_ok & (wbank_q == 1'b0);
        we1      = wr_ok & (wbank_q == 1'b1);
        out_fire = dout_valid_q & dout_ready;
        load_out = s1_valid_q & (~dout_valid_q | dout_ready);
        issue    = full_q[ibank_q] & (~s1_valid_q | load_out);
        re0      = issue & (ibank_q == 1'b0);
        re1      = issue & (ibank_q == 1'b1);

        if (data_valid & full_q[wbank_q]) begin
            overflow_d = 1'b1;
        end
        if (wr_ok) begin
            if (wcount_q == LAST_IDX) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = flip_bank(wbank_q);
                wcount_d        = '0;
            end else begin
                wcount_d = address_width'(wcount_q + 1'b1);
            end
        end

        if (issue) begin
            s1_valid_d = 1'b1;
            s1_index_d = raddr_q;
            s1_bank_d  = ibank_q;
            if (raddr_q == LAST_IDX) begin
                raddr_d = '0;
                ibank_d = flip_bank(ibank_q);
            end else begin
                raddr_d = address_width'(raddr_q + 1'b1);
            end
        end else if (load_out) begin
            s1_valid_d = 1'b0;
        end

        if (load_out) begin
            dout_d       = (s1_bank_q == 1'b1) ? rdata1 : rdata0;
            dout_index_d = s1_index_q;
            dout_valid_d = 1'b1;
        end else if (out_fire) begin
            dout_valid_d = 1'b0;
        end

        if (out_fire && (dout_index_q == LAST_IDX)) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = flip_bank(rbank_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q      <= 1'b0;
            wcount_q     <= '0;
            full_q       <= '0;
            overflow_q   <= 1'b0;
            ibank_q      <= 1'b0;
            raddr_q      <= '0;
            rbank_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_index_q   <= '0;
            s1_bank_q    <= 1'b0;
            dout_q       <= '0;
            dout_index_q <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wbank_q      <= wbank_d;
            wcount_q     <= wcount_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            ibank_q      <= ibank_d;
            raddr_q      <= raddr_d;
            rbank_q      <= rbank_d;
            s1_valid_q   <= s1_valid_d;
            s1_index_q   <= s1_index_d;
            s1_bank_q    <= s1_bank_d;
            dout_q       <= dout_d;
            dout_index_q <= dout_index_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_index = dout_index_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    // Marks the handshake itself, so it lines up with index N-1 on the bus.
    assign frame_done = dout_valid_q & dout_ready & (dout_index_q == LAST_IDX);

endmodule

// File: tb/tb_sdf_output_reorder.sv
// Directed bench for sdf_output_reorder: hand-computed frames checked at each handshake.
module tb_sdf_output_reorder;
    import sdf_output_reorder_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    coef_t sdf_out;
    addr_t out_address;
    logic  data_valid;
    coef_t dout;
    addr_t dout_index;
    logic  dout_valid;
    logic  dout_ready;
    logic  frame_done;
    logic  overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    coef_t q_data[$];
    addr_t q_idx[$];
    logic  q_fd[$];
    int    q_cyc[$];
    coef_t exp_data[$];

    logic  stall_seen = 1'b0;
    coef_t stall_data;
    addr_t stall_idx;

    sdf_output_reorder dut (
        .clk         (clk),
        .rst         (rst),
        .sdf_out     (sdf_out),
        .out_address (out_address),
        .data_valid  (data_valid),
        .dout        (dout),
        .dout_index  (dout_index),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Record every handshake and verify the output holds while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check_eq("stall_hold_data", 64'(dout), 64'(stall_data));
                check_eq("stall_hold_idx", 64'(dout_index), 64'(stall_idx));
                check_eq("stall_hold_valid", 64'(dout_valid), 64'd1);
            end
            stall_seen = dout_valid && !dout_ready;
            stall_data = dout;
            stall_idx  = dout_index;
            if (dout_valid && dout_ready) begin
                q_data.push_back(dout);
                q_idx.push_back(dout_index);
                q_fd.push_back(frame_done);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic addr_t bitrev(input addr_t a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic write_word(input addr_t a, input coef_t d);
        data_valid  = 1'b1;
        out_address = a;
        sdf_out     = d;
        tick();
        data_valid  = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_idx.delete();
        q_fd.delete();
        q_cyc.delete();
        exp_data.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_q();
    endtask

    // Wait (bounded) for n handshakes and compare them against exp_data in natural order.
    task automatic compare_frames(input string tag, input int n, input bit toggle, output int gaps);
        int budget = 400;
        gaps = 0;
        while (q_data.size() < n && budget > 0) begin
            if (toggle) dout_ready = ~dout_ready;
            tick();
            budget--;
        end
        check_eq({tag, "_count"}, 64'(q_data.size() >= n), 64'd1);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            check_eq({tag, "_data"}, 64'(q_data[i]), 64'(exp_data[i]));
            check_eq({tag, "_idx"}, 64'(q_idx[i]), 64'(i % 16));
            check_eq({tag, "_fdone"}, 64'(q_fd[i]), 64'((i % 16) == 15));
            if (i > 0 && (q_cyc[i] - q_cyc[i-1]) != 1) gaps++;
        end
        clear_q();
    endtask

    initial begin
        int gaps;
        addr_t a;
        rst         = 1'b1;
        data_valid  = 1'b0;
        sdf_out     = '0;
        out_address = '0;
        dout_ready  = 1'b1;

        // Reset state
        do_reset();
        check_eq("rst_valid", 64'(dout_valid), 64'd0);
        check_eq("rst_fdone", 64'(frame_done), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_dout", 64'(dout), 64'd0);
        check_eq("rst_idx", 64'(dout_index), 64'd0);

        // Bit-reversed frame, with fill-to-first-output latency
        for (int i = 0; i < 16; i++) begin
            a = bitrev(addr_t'(i));
            write_word(a, coef_t'(100 + int'(a)));
            exp_data.push_back(coef_t'(100 + i));
        end
        check_eq("lat_t0_valid", 64'(dout_valid), 64'd0);
        tick();
        check_eq("lat_t1_valid", 64'(dout_valid), 64'd0);
        tick();
        check_eq("lat_t2_valid", 64'(dout_valid), 64'd1);
        check_eq("lat_t2_idx", 64'(dout_index), 64'd0);
        check_eq("lat_t2_data", 64'(dout), 64'd100);
        compare_frames("bitrev", 16, 1'b0, gaps);
        check_eq("bitrev_ovf", 64'(overflow), 64'd0);

        // Two frames back to back, must drain with no bubble
        for (int i = 0; i < 16; i++) begin
            a = bitrev(addr_t'(i));
            write_word(a, coef_t'(200 + int'(a)));
        end
        for (int i = 0; i < 16; i++) write_word(addr_t'(15 - i), coef_t'(300 + 15 - i));
        for (int i = 0; i < 16; i++) exp_data.push_back(coef_t'(200 + i));
        for (int i = 0; i < 16; i++) exp_data.push_back(coef_t'(300 + i));
        compare_frames("b2b", 32, 1'b0, gaps);
        check_eq("b2b_gaps", 64'(gaps), 64'd0);

        // Ready toggling every cycle during fill and drain
        for (int i = 0; i < 16; i++) begin
            dout_ready = ~dout_ready;
            write_word(addr_t'(i), coef_t'(400 + i));
            exp_data.push_back(coef_t'(400 + i));
        end
        compare_frames("toggle", 16, 1'b1, gaps);
        dout_ready = 1'b1;
        tick();

        // Held back-pressure: third frame must be dropped and flag overflow
        do_reset();
        dout_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                write_word(addr_t'(i), coef_t'(500 + 100 * f + i));
                if (f == 1 && i == 15) check_eq("ovf_after32", 64'(overflow), 64'd0);
                if (f == 2 && i == 0)  check_eq("ovf_after33", 64'(overflow), 64'd1);
            end
        end
        for (int i = 0; i < 16; i++) exp_data.push_back(coef_t'(500 + i));
        for (int i = 0; i < 16; i++) exp_data.push_back(coef_t'(600 + i));
        dout_ready = 1'b1;
        compare_frames("ovf", 32, 1'b0, gaps);
        for (int i = 0; i < 40; i++) tick();
        check_eq("ovf_no_extra", 64'(q_data.size()), 64'd0);
        check_eq("ovf_sticky", 64'(overflow), 64'd1);
        clear_q();

        // Reset mid-frame: partial frame discarded
        do_reset();
        check_eq("rst_clears_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 7; i++) write_word(addr_t'(i), coef_t'(800 + i));
        rst = 1'b1;
        tick();
        check_eq("midrst_valid", 64'(dout_valid), 64'd0);
        check_eq("midrst_dout", 64'(dout), 64'd0);
        check_eq("midrst_idx", 64'(dout_index), 64'd0);
        tick();
        rst = 1'b0;
        clear_q();
        for (int i = 0; i < 16; i++) begin
            write_word(addr_t'(i), coef_t'(900 + i));
            check_eq("fresh_fill_valid", 64'(dout_valid), 64'd0);
            check_eq("fresh_fill_dout", 64'(dout), 64'd0);
            exp_data.push_back(coef_t'(900 + i));
        end
        compare_frames("fresh", 16, 1'b0, gaps);

        // Duplicate address: 3 written twice, 15 never written (keeps stale 615)
        write_word(addr_t'(3), coef_t'(7));
        for (int i = 0; i < 3; i++) write_word(addr_t'(i), coef_t'(1000 + i));
        write_word(addr_t'(3), coef_t'(9));
        for (int i = 4; i < 14; i++) write_word(addr_t'(i), coef_t'(1000 + i));
        for (int i = 0; i < 4; i++) tick();
        check_eq("dup_15w_valid", 64'(dout_valid), 64'd0);
        write_word(addr_t'(14), coef_t'(1014));
        for (int i = 0; i < 16; i++) begin
            if (i == 3)       exp_data.push_back(coef_t'(9));
            else if (i == 15) exp_data.push_back(coef_t'(615));
            else              exp_data.push_back(coef_t'(1000 + i));
        end
        compare_frames("dup", 16, 1'b0, gaps);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sdf_output_reorder.md
# sdf_output_reorder

Downstream stage of the SDF NTT/INTT pipeline. Captures the scrambled-order output stream (sdf_out tagged with out_address, qualified by data_valid) into one bank of a two-bank ping-pong buffer and, once a full polynomial has landed, streams it out in natural order 0..N-1 over a valid/ready interface. While one bank drains, the other fills, so back-to-back SDF frames are absorbed without stalling the pipeline.

## Interface
- data_width, 32, coefficient width
- address_width, 4, log2 of polynomial size; N = 2**address_width
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- sdf_out  input  data_width  coefficient from SDF stage
- out_address  input  address_width  natural-order index of sdf_out
- data_valid  input  1  sdf_out/out_address valid this cycle
- dout  output  data_width  coefficient, natural order
- dout_index  output  address_width  index of dout
- dout_valid  output  1  dout valid
- dout_ready  input  1  consumer accepts dout
- frame_done  output  1  one-cycle pulse on the handshake of index N-1
- overflow  output  1  sticky: a write arrived while both banks were full

## Operation
- Write side: wbank pointer (reset 0), wcount (reset 0). On data_valid with bank wbank not full: mem[wbank][out_address] <= sdf_out, wcount++. On the N-th write: full[wbank] <= 1, wbank toggles, wcount <= 0.
- wcount counts writes, not distinct addresses; duplicate addresses overwrite and still count.
- data_valid while full[wbank]=1: write dropped, wcount unchanged, overflow <= 1 (held until rst).
- Read side: rbank (reset 0), raddr (reset 0). Issue a read from mem[rbank][raddr] when full[rbank]=1 and the output register is empty or being consumed this cycle (dout_valid & dout_ready). After issuing raddr = N-1: no further reads from that bank; on the handshake of index N-1: full[rbank] <= 0, rbank toggles, frame_done pulses.
- Output register holds dout/dout_index stable while dout_valid=1 and dout_ready=0.
- Simultaneous write-bank fill and read-bank release in the same cycle: both take effect; no conflict since banks differ.
- Reset values: dout_valid 0, frame_done 0, overflow 0, dout 0, dout_index 0, all full flags 0, pointers 0. Memory contents are not cleared. Reset mid-frame discards both partial and complete frames.
- No arithmetic on data; width passes through unchanged.

## Timing
- Last (N-th) write at edge t; full flag set after t; first read issued at t+1; dout_valid=1 with index 0 after edge t+2 (2-cycle fill-to-first-output latency).
- With dout_ready held high: one coefficient per cycle, indices 0..N-1 consecutive, frame_done with index N-1.
- Back-pressure: a stalled output stalls raddr; write side is unaffected until both banks are full.
- Next frame's index 0 follows index N-1 with no bubble if the other bank is already full.
- Sustained throughput equals the SDF rate (N words per N cycles) when dout_ready=1.

## Structure
- Shared package: N = 2**address_width, bank-select type (1 bit), coefficient and address types sized from data_width/address_width.
- One sub-module: sdf_reorder_bank — 1 write port, 1 registered read port, depth N, instantiated twice (or one 2N-deep instance addressed {bank, addr}).
- Control (pointers, full flags, output register) lives in the top.

## Test plan
- Reset, then 16 writes with out_address in bit-reversed order 0,8,4,12,…,15 and sdf_out = 100+address, dout_ready=1 -> dout 100..115 with index 0..15, first dout_valid 2 cycles after the 16th write, frame_done on index 15, overflow 0.
- Two frames back-to-back (32 consecutive data_valid cycles), dout_ready=1 -> 32 consecutive outputs, no gap between frames, two frame_done pulses.
- dout_ready toggled 1/0 every cycle during drain -> dout/dout_index stable while stalled, all 16 values delivered once, in order.
- dout_ready=0 held, three full frames written -> first 32 writes stored, writes 33..48 dropped, overflow=1 from the 33rd write; release ready -> frames 1 and 2 exact.
- rst asserted after 7 writes of a frame, then a fresh full frame -> only the fresh frame is output, all outputs 0 during/after reset until its fill completes.
- Duplicate out_address 3 written twice (values 7 then 9) within a 16-write frame -> dout index 3 = 9, frame completes after the 16th write.
